xc_shift_sched: RTL and testbench
=================================

Name: xc_shift_sched

Overview:
Iterative shift/rotate engine plus scheduler. It shares one narrow shift/rotate step between two requesters: req0 is base-ISA shifts, req1 is bitmanip rotates (ror/rori). Each accepted operation is applied as a sequence of bounded per-cycle steps, and the result is returned with a valid/ready response handshake. Sits beside the ALU in execute; no architectural state.

Parameters:
XLEN, 32, datapath width (only 32 supported).
STEP, 8, max shift distance applied per cycle (power of two, 1..32).

Ports:
g_clk  in  1  clock.
g_reset  in  1  asynchronous reset, active-high.
flush  in  1  synchronous abort of any in-flight op.
req0_valid  in  1  requester 0 has an op.
req0_ready  out  1  requester 0 op accepted this cycle.
req0_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
req0_rs1  in  32  operand.
req0_shamt  in  5  shift amount.
req1_valid, req1_ready, req1_op, req1_rs1, req1_shamt: as req0, for requester 1.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer takes result.
rsp_id  out  1  requester that owns the result.
rsp_result  out  32  final value.
busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: rsp_valid=0, rsp_id=0, rsp_result=0, busy=0, rr_last=1 (so req0 wins the first tie).
- IDLE: reqN_ready is driven combinationally and is only ever high in IDLE with flush=0.
  - Grant rule: if exactly one reqN_valid, grant it. If both, grant the one != rr_last.
  - At most one ready is high per cycle.
  - On grant: latch op, rs1 into acc, shamt into rem, id into cur_id; set rr_last=id.
  - Next state: RUN if shamt!=0, else DONE.
- RUN, each cycle:
  - k = min(rem, STEP); acc = step(acc, op, k); rem = rem - k.
  - When rem becomes 0, go to DONE.
  - Number of RUN cycles is ceil(shamt/STEP).
- Step semantics, 0<=k<=STEP:
  - SLL: acc<<k.
  - SRL: acc>>k.
  - SRA: arithmetic >>k, sign-filled from acc[31].
  - ROR: (acc>>k)|(acc<<(32-k)), with k=0 giving acc unchanged.
  - Composition of steps equals the single-shot result by shamt.
- DONE:
  - rsp_valid=1, rsp_result=acc, rsp_id=cur_id.
  - All three are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE. A new grant is possible on the following cycle, not the same cycle.
- Latency: accept in cycle T; rsp_valid first high in cycle T+1+ceil(shamt/STEP).
- flush (any state): next state IDLE, rsp_valid deasserts next cycle, no response is produced, rr_last is unchanged. Flush in IDLE also blocks grant that cycle.
- g_reset asserted mid-operation: immediate return to reset values; the op is lost.
- Requesters must hold valid and payload until ready. The block samples payload only on the grant cycle.
- Simultaneous rsp_ready and flush in DONE: flush wins; treated as no handshake.

Decomposition:
- Package xc_shift_pkg:
  - op encodings: XC_SH_SLL, XC_SH_SRL, XC_SH_SRA, XC_SH_ROR.
  - FSM state encodings: IDLE, RUN, DONE.
  - STEP default constant.
- Sub-module xc_shift_step: purely combinational single step with inputs acc[31:0], op[1:0], k[$clog2(STEP):0], output res[31:0]. The top instantiates one copy. The top holds the FSM, arbiter, rem counter and response register.

Test Plan:
- ROR 0x80000001, shamt 1 on req1 alone: req1_ready in T; rsp_valid at T+2, rsp_result=0xC0000000, rsp_id=1.
- ROR 0x80000001, shamt 31, STEP=8: 4 RUN cycles; rsp_valid at T+5, rsp_result=0x00000003. Repeat with STEP=1: rsp_valid at T+32.
- shamt 0, SRL 0x12345678: no RUN cycles; rsp_valid at T+1, rsp_result=0x12345678.
- SRA 0x80000000, shamt 20: rsp_result=0xFFFFF800. SLL 0x00000001, shamt 31: rsp_result=0x80000000.
- Both valid from reset and held: grants alternate req0, req1, req0. With rsp_ready held low 5 cycles, rsp fields stay stable, both readys stay 0 and busy stays 1.
- Flush in the 2nd RUN cycle of shamt 31: no rsp_valid, IDLE next cycle, a new grant follows. g_reset pulse mid-RUN: all outputs return to reset values with no clock edge needed.

Source files
------------

// File: rtl/xc_shift_pkg.sv
// Shared encodings for the iterative shift/rotate scheduler.
package xc_shift_pkg;

  localparam int XC_XLEN     = 32;
  localparam int XC_STEP_DEF = 8;

  typedef enum logic [1:0] {
    XC_SH_SLL = 2'b00,
    XC_SH_SRL = 2'b01,
    XC_SH_SRA = 2'b10,
    XC_SH_ROR = 2'b11
  } xc_sh_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } xc_sh_state_e;

endpackage

// File: rtl/xc_shift_step.sv
// One bounded shift/rotate step: applies op by distance k (0..STEP) to acc.
module xc_shift_step
  import xc_shift_pkg::*;
#(
  parameter int STEP = XC_STEP_DEF
) (
  input  logic [31:0]          acc,
  input  logic [1:0]           op,
  input  logic [$clog2(STEP):0] k,
  output logic [31:0]          res
);

  logic [63:0] w_rot;

  // Shifting the doubled word keeps k=0 and k=32 rotates well defined.
  assign w_rot = {acc, acc} >> k;

  always_comb begin
    res = acc;
    case (op)
      XC_SH_SLL: res = acc << k;
      XC_SH_SRL: res = acc >> k;
      XC_SH_SRA: res = $signed(acc) >>> k;
      XC_SH_ROR: res = w_rot[31:0];
      default:   res = acc;
    endcase
  end

endmodule

// File: rtl/xc_shift_sched.sv
// Two-requester scheduler around a shared bounded shift/rotate step.
//   state | meaning
//   IDLE  | arbitrating, readys may assert
//   RUN   | applying up to STEP bits of shift per cycle
//   DONE  | result held on rsp_* until rsp_ready
module xc_shift_sched
  import xc_shift_pkg::*;
#(
  parameter int XLEN = XC_XLEN,
  parameter int STEP = XC_STEP_DEF
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [1:0]      req0_op,
  input  logic [XLEN-1:0] req0_rs1,
  input  logic [4:0]      req0_shamt,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [1:0]      req1_op,
  input  logic [XLEN-1:0] req1_rs1,
  input  logic [4:0]      req1_shamt,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_id,
  output logic [XLEN-1:0] rsp_result,
  output logic            busy
);

  localparam int KW = $clog2(STEP) + 1;

  xc_sh_state_e    r_state, w_state_nxt;
  logic [1:0]      r_op;
  logic [XLEN-1:0] r_acc;
  logic [4:0]      r_rem;
  logic            r_cur_id;
  logic            r_rr_last;

  logic            w_idle_ok, w_gnt0, w_gnt1, w_gnt;
  logic [4:0]      w_shamt;
  logic [KW-1:0]   w_k;
  logic [4:0]      w_rem_nxt;
  logic [XLEN-1:0] w_res;

  // rr_last==1 means req1 went last, so req0 wins a tie.
  assign w_idle_ok = (r_state == IDLE) && !flush;
  assign w_gnt0    = w_idle_ok && req0_valid && (!req1_valid || r_rr_last);
  assign w_gnt1    = w_idle_ok && req1_valid && (!req0_valid || !r_rr_last);
  assign w_gnt     = w_gnt0 || w_gnt1;
  assign w_shamt   = w_gnt1 ? req1_shamt : req0_shamt;

  always_comb begin
    w_k = KW'(r_rem);
    if (int'(r_rem) >= STEP) w_k = KW'(STEP);
  end

  assign w_rem_nxt = r_rem - 5'(w_k);

  xc_shift_step #(.STEP(STEP)) u_step (
    .acc (r_acc),
    .op  (r_op),
    .k   (w_k),
    .res (w_res)
  );

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_gnt) w_state_nxt = (w_shamt != 5'd0) ? RUN : DONE;
      RUN:     if (w_rem_nxt == 5'd0) w_state_nxt = DONE;
      DONE:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      r_op      <= 2'b00;
      r_acc     <= '0;
      r_rem     <= 5'd0;
      r_cur_id  <= 1'b0;
      r_rr_last <= 1'b1;
    end else if (w_gnt) begin
      r_op      <= w_gnt1 ? req1_op : req0_op;
      r_acc     <= w_gnt1 ? req1_rs1 : req0_rs1;
      r_rem     <= w_shamt;
      r_cur_id  <= w_gnt1;
      r_rr_last <= w_gnt1;
    end else if (r_state == RUN && !flush) begin
      r_acc <= w_res;
      r_rem <= w_rem_nxt;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp_valid  = (r_state == DONE);
  assign rsp_id     = r_cur_id;
  assign rsp_result = r_acc;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_xc_shift_sched.sv
// Directed bench for xc_shift_sched: vector table plus arbitration/flush/reset sequences.
module tb_xc_shift_sched;
  import xc_shift_pkg::*;

  logic        g_clk = 1'b0;
  logic        g_reset, flush;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_rs1, req1_rs1;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_result;

  // second instance with STEP=1
  logic        s1_req0_valid, s1_req0_ready, s1_req1_ready;
  logic [1:0]  s1_req0_op;
  logic [31:0] s1_req0_rs1;
  logic [4:0]  s1_req0_shamt;
  logic        s1_rsp_valid, s1_rsp_id, s1_busy;
  logic [31:0] s1_rsp_result;

  int total = 0;
  int bad   = 0;

  always #5 g_clk = ~g_clk;

  xc_shift_sched #(.XLEN(32), .STEP(8)) dut (
    .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_rs1(req0_rs1), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_rs1(req1_rs1), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .busy(busy)
  );

  xc_shift_sched #(.XLEN(32), .STEP(1)) dut_s1 (
    .g_clk(g_clk), .g_reset(g_reset), .flush(1'b0),
    .req0_valid(s1_req0_valid), .req0_ready(s1_req0_ready), .req0_op(s1_req0_op),
    .req0_rs1(s1_req0_rs1), .req0_shamt(s1_req0_shamt),
    .req1_valid(1'b0), .req1_ready(s1_req1_ready), .req1_op(2'b00),
    .req1_rs1(32'h0), .req1_shamt(5'd0),
    .rsp_valid(s1_rsp_valid), .rsp_ready(1'b1), .rsp_id(s1_rsp_id),
    .rsp_result(s1_rsp_result), .busy(s1_busy)
  );

  typedef struct {
    int          id;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [4:0]  sh;
    logic [31:0] res;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin
      @(negedge g_clk);
      n++;
    end while (!rsp_valid && n < 60);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
  endtask

  // Called at drive time (1 unit after posedge) with the DUT idle.
  task automatic do_op(input int id, input logic [1:0] op, input logic [31:0] rs1,
                       input logic [4:0] sh, input logic [31:0] exp_res, input int exp_lat);
    int n;
    if (id == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_rs1 = rs1; req0_shamt = sh;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_rs1 = rs1; req1_shamt = sh;
    end
    @(negedge g_clk);
    chk("grant_ready", (id == 0) ? req0_ready : req1_ready, 1);
    chk("other_ready", (id == 0) ? req1_ready : req0_ready, 0);
    @(posedge g_clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(n);
    chk("latency", n, exp_lat);
    chk("result", rsp_result, exp_res);
    chk("rsp_id", rsp_id, id);
    handshake();
  endtask

  initial begin
    int n;
    vecs[0] = '{1, XC_SH_ROR, 32'h80000001, 5'd1,  32'hC0000000, 2};
    vecs[1] = '{0, XC_SH_ROR, 32'h80000001, 5'd31, 32'h00000003, 5};
    vecs[2] = '{0, XC_SH_SRL, 32'h12345678, 5'd0,  32'h12345678, 1};
    vecs[3] = '{1, XC_SH_SRA, 32'h80000000, 5'd20, 32'hFFFFF800, 4};
    vecs[4] = '{0, XC_SH_SLL, 32'h00000001, 5'd31, 32'h80000000, 5};
    vecs[5] = '{1, XC_SH_SRL, 32'hF0000000, 5'd8,  32'h00F00000, 2};
    vecs[6] = '{1, XC_SH_SLL, 32'h000000FF, 5'd16, 32'h00FF0000, 3};
    vecs[7] = '{0, XC_SH_ROR, 32'h12345678, 5'd8,  32'h78123456, 2};
    vecs[8] = '{0, XC_SH_SRA, 32'h40000000, 5'd9,  32'h00200000, 3};
    vecs[9] = '{1, XC_SH_ROR, 32'h0000FFFF, 5'd17, 32'h7FFF8000, 4};

    g_reset = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_op = 2'b00; req0_rs1 = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_rs1 = '0; req1_shamt = '0;
    s1_req0_valid = 1'b0; s1_req0_op = 2'b00; s1_req0_rs1 = '0; s1_req0_shamt = '0;
    #12;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_busy", busy, 0);
    g_reset = 1'b0;
    @(posedge g_clk); #1;

    for (int i = 0; i < 10; i++)
      do_op(vecs[i].id, vecs[i].op, vecs[i].rs1, vecs[i].sh, vecs[i].res, vecs[i].lat);

    // flush in IDLE blocks grant, then flush in 2nd RUN cycle aborts
    req0_valid = 1'b1; req0_op = XC_SH_ROR; req0_rs1 = 32'h80000001; req0_shamt = 5'd31;
    flush = 1'b1;
    @(negedge g_clk);
    chk("flush_blocks_grant", req0_ready, 0);
    @(posedge g_clk); #1;
    flush = 1'b0;
    @(negedge g_clk);
    chk("flush_op_grant", req0_ready, 1);
    @(posedge g_clk); #1;
    req0_valid = 1'b0;
    @(posedge g_clk); #1;
    flush = 1'b1;
    @(negedge g_clk);
    chk("flush_busy_run2", busy, 1);
    @(posedge g_clk); #1;
    flush = 1'b0;
    @(negedge g_clk);
    chk("flush_idle", busy, 0);
    for (int i = 0; i < 6; i++) begin
      chk("flush_no_rsp", rsp_valid, 0);
      @(negedge g_clk);
    end
    @(posedge g_clk); #1;
    do_op(1, XC_SH_SRL, 32'h00000080, 5'd3, 32'h00000010, 2);

    // async reset mid-RUN
    req0_valid = 1'b1; req0_op = XC_SH_ROR; req0_rs1 = 32'h80000001; req0_shamt = 5'd31;
    @(negedge g_clk);
    chk("rstmid_grant", req0_ready, 1);
    @(posedge g_clk); #1;
    req0_valid = 1'b0;
    @(posedge g_clk); #3;
    g_reset = 1'b1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    chk("rstmid_rsp_result", rsp_result, 0);
    chk("rstmid_rsp_id", rsp_id, 0);
    @(negedge g_clk);
    g_reset = 1'b0;
    @(posedge g_clk); #1;

    // both requesters held valid: req0, req1, req0
    req0_valid = 1'b1; req0_op = XC_SH_SLL; req0_rs1 = 32'h1; req0_shamt = 5'd4;
    req1_valid = 1'b1; req1_op = XC_SH_ROR; req1_rs1 = 32'h1; req1_shamt = 5'd4;
    @(negedge g_clk);
    chk("rr1_ready0", req0_ready, 1);
    chk("rr1_ready1", req1_ready, 0);
    @(posedge g_clk); #1;
    wait_rsp(n);
    chk("rr1_latency", n, 2);
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", rsp_valid, 1);
      chk("hold_result", rsp_result, 32'h00000010);
      chk("hold_id", rsp_id, 0);
      chk("hold_busy", busy, 1);
      chk("hold_readys", {req0_ready, req1_ready}, 0);
      @(negedge g_clk);
    end
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
    @(negedge g_clk);
    chk("rr2_ready0", req0_ready, 0);
    chk("rr2_ready1", req1_ready, 1);
    @(posedge g_clk); #1;
    wait_rsp(n);
    chk("rr2_latency", n, 2);
    chk("rr2_result", rsp_result, 32'h10000000);
    chk("rr2_id", rsp_id, 1);
    rsp_ready = 1'b1;
    @(posedge g_clk); #1;
    rsp_ready = 1'b0;
    @(negedge g_clk);
    chk("rr3_ready0", req0_ready, 1);
    chk("rr3_ready1", req1_ready, 0);
    @(posedge g_clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    wait_rsp(n);
    chk("rr3_result", rsp_result, 32'h00000010);
    chk("rr3_id", rsp_id, 0);
    handshake();

    // STEP=1 instance: 31 RUN cycles
    s1_req0_valid = 1'b1; s1_req0_op = XC_SH_ROR; s1_req0_rs1 = 32'h80000001; s1_req0_shamt = 5'd31;
    @(negedge g_clk);
    chk("s1_grant", s1_req0_ready, 1);
    @(posedge g_clk); #1;
    s1_req0_valid = 1'b0;
    n = 0;
    do begin
      @(negedge g_clk);
      n++;
    end while (!s1_rsp_valid && n < 60);
    chk("s1_latency", n, 32);
    chk("s1_result", s1_rsp_result, 32'h00000003);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
